// File: rtl/decode_execute_reg_pkg.sv
// Shared decode/execute definitions: control bundle, its NOP value and ALU opcodes.
// The control bundle is reused by the execute stage, so keep the field order stable.
package decode_execute_reg_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/decode_execute_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {WIDTH{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with stall (hold) and flush (bubble) controls.
// Define PERF_CNT_EN to build a saturating counter of inserted bubbles.
module decode_execute_reg
    import decode_execute_reg_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    input  logic                      RegWriteD,
    input  logic                      MemWriteD,
    input  logic                      JumpD,
    input  logic                      BranchD,
    input  logic                      ALUSrcD,
    input  logic [1:0]                ResultSrcD,
    input  logic [2:0]                ALUControlD,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic                      RegWriteE,
    output logic                      MemWriteE,
    output logic                      JumpE,
    output logic                      BranchE,
    output logic                      ALUSrcE,
    output logic [1:0]                ResultSrcE,
    output logic [2:0]                ALUControlE,
    output logic                      ValidE,
    output logic [CNT_WIDTH-1:0]      BubbleCountE
);

    logic [DATA_WIDTH-1:0]     rd1_q, rd2_q, pc_q, pcp4_q, imm_q;
    logic [DATA_WIDTH-1:0]     rd1_d, rd2_d, pc_d, pcp4_d, imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_d, rs2_d, rd_d;
    ctrl_t                     ctrl_q, ctrl_d, ctrl_in;
    logic                      valid_q, valid_d;

    always_comb begin
        ctrl_in            = CTRL_NOP;
        ctrl_in.RegWrite   = RegWriteD;
        ctrl_in.ResultSrc  = ResultSrcD;
        ctrl_in.MemWrite   = MemWriteD;
        ctrl_in.Jump       = JumpD;
        ctrl_in.Branch     = BranchD;
        ctrl_in.ALUControl = ALUControlD;
        ctrl_in.ALUSrc     = ALUSrcD;
    end

    // Flush beats stall; with neither asserted the D side is captured.
    always_comb begin
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        pc_d    = pc_q;
        pcp4_d  = pcp4_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (FlushE) begin
            rd1_d   = '0;
            rd2_d   = '0;
            pc_d    = '0;
            pcp4_d  = '0;
            imm_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            ctrl_d  = CTRL_NOP;
            valid_d = 1'b0;
        end else if (!StallE) begin
            rd1_d   = RD1D;
            rd2_d   = RD2D;
            pc_d    = PCD;
            pcp4_d  = PCPlus4D;
            imm_d   = ImmExtD;
            rs1_d   = Rs1D;
            rs2_d   = Rs2D;
            rd_d    = RdD;
            ctrl_d  = ctrl_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_q   <= '0;
            rd2_q   <= '0;
            pc_q    <= '0;
            pcp4_q  <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= CTRL_NOP;
            valid_q <= 1'b0;
        end else begin
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            pc_q    <= pc_d;
            pcp4_q  <= pcp4_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pcp4_q;
    assign ImmExtE     = imm_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;
    assign RegWriteE   = ctrl_q.RegWrite;
    assign ResultSrcE  = ctrl_q.ResultSrc;
    assign MemWriteE   = ctrl_q.MemWrite;
    assign JumpE       = ctrl_q.Jump;
    assign BranchE     = ctrl_q.Branch;
    assign ALUControlE = ctrl_q.ALUControl;
    assign ALUSrcE     = ctrl_q.ALUSrc;
    assign ValidE      = valid_q;

`ifdef PERF_CNT_EN
    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_bubble_cnt (
        .clk     (clk),
        .clr_i   (rst),
        .en_i    (FlushE),
        .count_o (BubbleCountE)
    );
`else
    assign BubbleCountE = '0;
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Randomized bench for decode_execute_reg against a transaction-level model.
module tb_decode_execute_reg;

    localparam int CW = 3;

    typedef struct packed {
        logic [31:0] rd1, rd2, pc, pcp4, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        regwrite, memwrite, jump, branch, alusrc;
        logic [1:0]  resultsrc;
        logic [2:0]  aluctl;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1, StallE = 1'b0, FlushE = 1'b0;
    instr_t din, eout;
    logic   ValidE;
    logic [CW-1:0] BubbleCountE;

    instr_t exp_e;
    logic   exp_v;
    int     exp_cnt;
    int     n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    decode_execute_reg #(
        .DATA_WIDTH (32), .REG_ADDR_WIDTH (5), .CNT_WIDTH (CW)
    ) dut (
        .clk (clk), .rst (rst), .StallE (StallE), .FlushE (FlushE),
        .RD1D (din.rd1), .RD2D (din.rd2), .PCD (din.pc),
        .PCPlus4D (din.pcp4), .ImmExtD (din.imm),
        .Rs1D (din.rs1), .Rs2D (din.rs2), .RdD (din.rd),
        .RegWriteD (din.regwrite), .MemWriteD (din.memwrite),
        .JumpD (din.jump), .BranchD (din.branch), .ALUSrcD (din.alusrc),
        .ResultSrcD (din.resultsrc), .ALUControlD (din.aluctl),
        .RD1E (eout.rd1), .RD2E (eout.rd2), .PCE (eout.pc),
        .PCPlus4E (eout.pcp4), .ImmExtE (eout.imm),
        .Rs1E (eout.rs1), .Rs2E (eout.rs2), .RdE (eout.rd),
        .RegWriteE (eout.regwrite), .MemWriteE (eout.memwrite),
        .JumpE (eout.jump), .BranchE (eout.branch), .ALUSrcE (eout.alusrc),
        .ResultSrcE (eout.resultsrc), .ALUControlE (eout.aluctl),
        .ValidE (ValidE), .BubbleCountE (BubbleCountE)
    );

    task automatic check(input string tag, input logic [191:0] got,
                         input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic instr_t rand_instr();
        instr_t t;
        t.rd1 = $urandom; t.rd2 = $urandom; t.pc = $urandom;
        t.pcp4 = $urandom; t.imm = $urandom;
        t.rs1 = 5'($urandom); t.rs2 = 5'($urandom); t.rd = 5'($urandom);
        t.regwrite = 1'($urandom); t.memwrite = 1'($urandom);
        t.jump = 1'($urandom); t.branch = 1'($urandom);
        t.alusrc = 1'($urandom); t.resultsrc = 2'($urandom);
        t.aluctl = 3'($urandom);
        return t;
    endfunction

    // One clock: the model applies the E-stage rules to what D presented.
    task automatic cyc(input logic r, input logic f, input logic s);
        rst = r; FlushE = f; StallE = s;
        @(posedge clk);
        if (r) begin
            exp_e = '0; exp_v = 1'b0; exp_cnt = 0;
        end else if (f) begin
            exp_e = '0; exp_v = 1'b0;
`ifdef PERF_CNT_EN
            if (exp_cnt < (1 << CW) - 1) exp_cnt = exp_cnt + 1;
`endif
        end else if (!s) begin
            exp_e = din; exp_v = 1'b1;
        end
        #1;
        check("fields", 192'(eout), 192'(exp_e));
        check("valid", 192'(ValidE), 192'(exp_v));
        check("bubbles", 192'(BubbleCountE), 192'(exp_cnt));
    endtask

    initial begin
        instr_t a, b;
        exp_e = '0; exp_v = 1'b0; exp_cnt = 0;
        din = rand_instr();
        din.rd1 = 32'hDEAD_BEEF;
        cyc(1, 0, 0);
        cyc(1, 1, 1);
        check("rst_rd1", 192'(eout.rd1), 192'(0));

        din = '0;
        din.rd1 = 32'h0000_1234; din.rd = 5'd5;
        din.regwrite = 1'b1; din.aluctl = 3'b001;
        cyc(0, 0, 0);
        check("load_rd1", 192'(eout.rd1), 192'(32'h0000_1234));
        check("load_rd", 192'(eout.rd), 192'(5));
        check("load_alu", 192'(eout.aluctl), 192'(3'b001));

        a = rand_instr(); a.memwrite = 1'b1;
        b = rand_instr();
        din = a; cyc(0, 0, 0);
        din = b;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        check("stall_hold", 192'(eout), 192'(a));
        cyc(0, 0, 0);
        check("stall_release", 192'(eout), 192'(b));

        din = a; cyc(0, 0, 0);
        din = b; cyc(0, 1, 1);
        check("flush_memwrite", 192'(eout.memwrite), 192'(0));

        din.aluctl = 3'b101; cyc(0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, (i % 2) == 1);
        cyc(1, 1, 0);

        for (int i = 0; i < 400; i++) begin
            din = rand_instr();
            cyc($urandom_range(0, 39) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_execute_reg.md
# decode_execute_reg

Decode/execute pipeline register of the pipelined RISC-V core. Captures decoded operands, immediates, register indices and control signals from the decode stage each cycle and presents them to the execute stage (ALU operand muxes, branch logic, forwarding unit). Supports a hold (stall) and a bubble insert (flush) driven by the hazard unit. Optionally keeps a saturating count of inserted bubbles for performance analysis.

## Interface
- DATA_WIDTH, 32, width of operand, PC and immediate fields
- REG_ADDR_WIDTH, 5, width of register index fields
- CNT_WIDTH, 32, width of the bubble counter (used only with PERF_CNT_EN)

- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- StallE  in  1  hold all E outputs at their current value
- FlushE  in  1  load a bubble (NOP) instead of the D inputs
- RD1D, RD2D  in  DATA_WIDTH  register file read data
- PCD, PCPlus4D, ImmExtD  in  DATA_WIDTH  PC, PC+4, sign-extended immediate
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH  source and destination indices
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decoded control
- ResultSrcD  in  2  writeback result select
- ALUControlD  in  3  ALU operation code
- RD1E … ALUControlE  out  same widths as D counterparts  registered copies
- ValidE  out  1  1 = E stage holds a real instruction, 0 = bubble
- BubbleCountE  out  CNT_WIDTH  number of bubbles inserted (0 without PERF_CNT_EN)

## Operation
- Normal (rst=0, FlushE=0, StallE=0): every E output takes its D input on the edge; ValidE becomes 1.
- Stall (StallE=1, FlushE=0): all E outputs and ValidE hold.
- Flush (FlushE=1): all data, index and control E outputs become 0; ValidE becomes 0. Result is a NOP: RegWriteE=MemWriteE=JumpE=BranchE=0, ALUControlE=3'b000 (add).
- Priority: rst > FlushE > StallE > load. FlushE and StallE together → flush.
- Reset: all E outputs 0, ValidE 0, BubbleCountE 0. Reset asserted mid-stall or mid-flush overrides on the same edge.
- Fields pass through unchanged; no decoding, sign-extension or width conversion; ALUControlD values 3'b101 and undefined codes pass through as-is.
- Bubble count: increments by 1 on each edge where FlushE=1 and rst=0, including repeated flushes and flushes during stall; saturates at 2^CNT_WIDTH-1 (no wrap). Reset clears it.

## Timing
- Latency 1 cycle D → E; no combinational path from any input to any output.
- StallE/FlushE sampled on the same edge as the D inputs; effect visible the cycle after assertion.
- A stall of N cycles holds outputs for N cycles; release loads the D inputs present on the release edge.
- BubbleCountE updates on the same edge the bubble is loaded.

## Configuration
- PERF_CNT_EN defined: saturating bubble counter built, BubbleCountE driven by it.
- PERF_CNT_EN undefined: counter not instantiated, BubbleCountE tied to 0; all other behaviour identical.

## Structure
- Shared package holds: control-bundle struct (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc), its NOP constant (all zero), and ALU opcode constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLL=110, SRL=111) shared with the execute stage.
- One sub-module: sat_counter (enable, sync clear, saturating, parameterised width), instantiated only under PERF_CNT_EN.

## Test plan
- Reset: hold rst=1 with D inputs nonzero for 2 cycles → all E outputs 0, ValidE=0, BubbleCountE=0.
- Load: RD1D=0x0000_1234, RdD=5, RegWriteD=1, ALUControlD=001 → next cycle RD1E=0x0000_1234, RdE=5, RegWriteE=1, ALUControlE=001, ValidE=1.
- Stall: load instruction A, then StallE=1 for 3 cycles while D changes to B → E holds A for 3 cycles, shows B the cycle after StallE drops.
- Flush with stall: E holds A with MemWriteE=1, then FlushE=1 and StallE=1 together → next cycle all E fields 0, ValidE=0, BubbleCountE increments by 1.
- Counter saturation (PERF_CNT_EN, CNT_WIDTH=3): 9 consecutive flushes → BubbleCountE reads 1..7 then stays 7; rst → 0. Without macro: BubbleCountE stays 0 throughout.
